// File: rtl/cordic_prep_pipe.sv
// cordic_prep_pipe: streaming front-end producing x/2, x^2 and an offset/scaled fixed angle word
// for the CORDIC core, with a credit-protected in-order output FIFO.

// fp_mul: binary32 multiplier, round-to-nearest-even, denormals flushed, LATENCY register stages.
module fp_mul #(
    parameter int LATENCY = 5
) (
    input  logic        clk,
    input  logic        i_en,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_p
);
    logic [7:0]        w_ea, w_eb;
    logic              w_an, w_ai, w_az, w_bn, w_bi, w_bz, w_s, w_norm, w_g, w_st;
    logic [47:0]       w_p;
    logic [22:0]       w_frac;
    logic [23:0]       w_rnd;
    logic signed [9:0] w_e;
    logic [31:0]       w_res;
    logic [31:0]       r_p [LATENCY];

    assign w_ea   = i_a[30:23];
    assign w_eb   = i_b[30:23];
    assign w_an   = (&w_ea) & (|i_a[22:0]);
    assign w_ai   = (&w_ea) & ~(|i_a[22:0]);
    assign w_az   = ~(|w_ea);
    assign w_bn   = (&w_eb) & (|i_b[22:0]);
    assign w_bi   = (&w_eb) & ~(|i_b[22:0]);
    assign w_bz   = ~(|w_eb);
    assign w_s    = i_a[31] ^ i_b[31];
    assign w_p    = 48'({1'b1, i_a[22:0]}) * 48'({1'b1, i_b[22:0]});
    assign w_norm = w_p[47];
    assign w_frac = w_norm ? w_p[46:24] : w_p[45:23];
    assign w_g    = w_norm ? w_p[23] : w_p[22];
    assign w_st   = w_norm ? |w_p[22:0] : |w_p[21:0];
    // A rounding carry turns 1.11..1 into 10.0, so the fraction becomes zero and the exponent bumps.
    assign w_rnd  = {1'b0, w_frac} + {23'b0, w_g & (w_st | w_frac[0])};
    assign w_e    = $signed({2'b0, w_ea}) + $signed({2'b0, w_eb}) + $signed({9'b0, w_norm})
                  + $signed({9'b0, w_rnd[23]}) - 10'sd127;
    assign w_res  = (w_an | w_bn | (w_ai & w_bz) | (w_bi & w_az)) ? 32'h7FC00000 :
                    (w_ai | w_bi | (w_e > 10'sd254))             ? {w_s, 8'hFF, 23'b0} :
                    (w_az | w_bz | (w_e < 10'sd1))               ? {w_s, 31'b0} :
                    {w_s, w_e[7:0], w_rnd[23] ? 23'b0 : w_rnd[22:0]};

    always_ff @(posedge clk) begin
        if (i_en) begin
            r_p[0] <= w_res;
            for (int i = 1; i < LATENCY; i++) r_p[i] <= r_p[i-1];
        end
    end

    assign o_p = r_p[LATENCY-1];
endmodule

module cordic_prep_pipe #(
    parameter int                FLT_W       = 32,
    parameter int                MUL_LATENCY = 5,
    parameter int                FRAC_BITS   = 14,
    parameter int                CONV_W      = 24,
    parameter logic [CONV_W-1:0] OFFSET      = 24'h200000,
    parameter int                SHIFT       = 7,
    parameter int                OUT_W       = 22,
    parameter int                FIFO_DEPTH  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [FLT_W-1:0] x,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [FLT_W-1:0] half,
    output logic [FLT_W-1:0] square,
    output logic [OUT_W-1:0] x_fixed,
    output logic             sat
);
    localparam int ML = MUL_LATENCY;
    localparam int MW = CONV_W + 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = 2 * FLT_W + OUT_W + 1;
    localparam logic [MW-1:0]        C_MAX = MW'((64'd1 << (CONV_W - 1)) - 64'd1);
    localparam logic signed [63:0]   O_MAX = (64'sd1 <<< (OUT_W - 1)) - 64'sd1;
    localparam logic signed [63:0]   O_MIN = -O_MAX - 64'sd1;

    logic                     w_acc, w_wr, w_rd, w_nan, w_covf, w_oovf;
    logic [7:0]               w_e8;
    logic signed [9:0]        w_sh;
    logic [MW-1:0]            w_mag;
    logic [CONV_W-1:0]        w_c;
    logic signed [CONV_W:0]   w_d, w_q;
    logic signed [63:0]       w_qx;
    logic [OUT_W-1:0]         w_xf;
    logic [FLT_W-1:0]         w_half, w_sq;
    logic [ML-1:0]            r_vld;
    logic [FLT_W-1:0]         r_half [ML];
    logic [OUT_W-1:0]         r_xf [ML];
    logic                     r_sat [ML];
    logic [EW-1:0]            r_mem [FIFO_DEPTH];
    logic [PW-1:0]            r_wp, r_rp;
    logic [CW-1:0]            r_cnt, r_infl;

    assign w_acc    = in_valid & in_ready & ~rst;
    assign w_wr     = r_vld[ML-1];
    assign w_rd     = out_valid & out_ready;
    assign in_ready = ({1'b0, r_infl} + {1'b0, r_cnt}) < (CW + 1)'(FIFO_DEPTH);
    assign out_valid = r_cnt != '0;

    assign w_e8   = x[30:23];
    assign w_half = (w_e8 < 8'd2) ? {x[31], 31'b0} : (&w_e8) ? x : {x[31], w_e8 - 8'd1, x[22:0]};

    // w_sh is the left shift that scales the 24-bit significand to FRAC_BITS fractional bits.
    assign w_nan  = (&w_e8) & (|x[22:0]);
    assign w_sh   = $signed({2'b0, w_e8}) - $signed(10'(150 - FRAC_BITS));
    assign w_mag  = w_sh[9] ? MW'({|w_e8, x[22:0]}) >> 10'(-w_sh) : MW'({|w_e8, x[22:0]}) << w_sh;
    assign w_covf = ~w_nan & ((w_sh > $signed(10'(CONV_W - 24))) | (x[31] ? (w_mag > C_MAX + 1'b1) : (w_mag > C_MAX)));
    assign w_c    = w_nan  ? '0 :
                    w_covf ? (x[31] ? {1'b1, {(CONV_W-1){1'b0}}} : {1'b0, {(CONV_W-1){1'b1}}}) :
                    x[31]  ? -w_mag[CONV_W-1:0] : w_mag[CONV_W-1:0];
    assign w_d    = $signed({w_c[CONV_W-1], w_c}) - $signed({OFFSET[CONV_W-1], OFFSET});
    assign w_q    = w_d >>> SHIFT;
    assign w_qx   = {{(63-CONV_W){w_q[CONV_W]}}, w_q};
    assign w_oovf = (w_qx > O_MAX) | (w_qx < O_MIN);
    assign w_xf   = (w_qx > O_MAX) ? O_MAX[OUT_W-1:0] : (w_qx < O_MIN) ? O_MIN[OUT_W-1:0] : w_qx[OUT_W-1:0];

    fp_mul #(.LATENCY(ML)) u_sq (
        .clk  (clk),
        .i_en (1'b1),
        .i_a  (x),
        .i_b  (x),
        .o_p  (w_sq)
    );

    always_ff @(posedge clk) begin
        r_half[0] <= w_half;
        r_xf[0]   <= w_xf;
        r_sat[0]  <= w_nan | w_covf | w_oovf;
        for (int i = 1; i < ML; i++) begin
            r_half[i] <= r_half[i-1];
            r_xf[i]   <= r_xf[i-1];
            r_sat[i]  <= r_sat[i-1];
        end
        if (w_wr) r_mem[r_wp] <= {r_half[ML-1], w_sq, r_xf[ML-1], r_sat[ML-1]};
        if (rst) begin
            r_vld  <= '0;
            r_wp   <= '0;
            r_rp   <= '0;
            r_cnt  <= '0;
            r_infl <= '0;
        end else begin
            r_vld  <= {r_vld[ML-2:0], w_acc};
            r_wp   <= r_wp + PW'(w_wr);
            r_rp   <= r_rp + PW'(w_rd);
            r_cnt  <= r_cnt + CW'(w_wr) - CW'(w_rd);
            r_infl <= r_infl + CW'(w_acc) - CW'(w_wr);
        end
    end

    assign {half, square, x_fixed, sat} = out_valid ? r_mem[r_rp] : '0;
endmodule

// File: tb/tb_cordic_prep_pipe.sv
// tb_cordic_prep_pipe: directed vectors, backpressure, reset and randomized traffic against a
// real-arithmetic reference model and an in-order expectation queue.
module tb_cordic_prep_pipe;
    typedef struct packed {
        logic [31:0] h;
        logic [31:0] q;
        logic [21:0] f;
        logic        s;
    } exp_t;

    logic        clk = 0, rst = 1, in_valid = 0, out_ready = 0;
    logic [31:0] x = 0;
    logic        in_ready, out_valid, sat;
    logic [31:0] half, square;
    logic [21:0] x_fixed;
    exp_t        got;
    exp_t        q[$];
    int          checks = 0, failures = 0;

    cordic_prep_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .x(x),
        .out_valid(out_valid), .out_ready(out_ready), .half(half), .square(square),
        .x_fixed(x_fixed), .sat(sat)
    );

    always #5 clk = ~clk;
    assign got = {half, square, x_fixed, sat};

    function automatic real f2r(input logic [31:0] a);
        return $bitstoreal({a[31], 11'(int'(a[30:23]) + 896), a[22:0], 29'b0});
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] b;
        b = $realtobits(r);
        return {b[63], 8'(int'(b[62:52]) - 896), b[51:29]};
    endfunction

    function automatic exp_t model(input logic [31:0] a);
        exp_t r;
        int   e, c, qv;
        bit   nan, inf, s;
        real  v, t, p, minn, maxn;
        minn = $bitstoreal(64'h3810000000000000);
        maxn = $bitstoreal(64'h47F0000000000000);
        e   = int'(a[30:23]);
        nan = e == 255 && a[22:0] != 0;
        inf = e == 255 && a[22:0] == 0;
        v   = (e == 0 || e == 255) ? 0.0 : f2r(a);
        r.h = (e == 255) ? a : ((v / 2.0 < minn && v / 2.0 > -minn) ? {a[31], 31'b0} : r2f(v / 2.0));
        p   = v * v;
        r.q = nan ? 32'h7FC00000 : inf ? 32'h7F800000 : (p >= maxn) ? 32'h7F800000 : (p < minn) ? 32'h0 : r2f(p);
        s   = nan || inf;
        t   = v * 16384.0;
        if (nan) c = 0;
        else if (inf) c = a[31] ? -8388608 : 8388607;
        else if (t >= 8388608.0) begin c = 8388607; s = 1; end
        else if (t <= -8388609.0) begin c = -8388608; s = 1; end
        else c = $rtoi(t);
        qv = (c - 2097152) >>> 7;
        if (qv > 2097151) begin qv = 2097151; s = 1; end
        else if (qv < -2097152) begin qv = -2097152; s = 1; end
        r.f = qv[21:0];
        r.s = s;
        return r;
    endfunction

    function automatic logic [31:0] rand_op();
        int          k;
        logic [31:0] r;
        k = $urandom_range(0, 19);
        r[31] = 1'($urandom_range(0, 1));
        r[22:0] = {11'($urandom), 12'b0};
        if (k == 0) r[30:0] = '0;
        else if (k == 1) r[30:0] = {8'hFF, 23'b0};
        else if (k == 2) r[30:0] = {8'hFF, 23'($urandom_range(1, 8388607))};
        else if (k == 3) r[30:0] = {8'h00, 23'($urandom_range(1, 8388607))};
        else if (k == 4) r[30:23] = 8'd1;
        else if (k == 5) r[30:23] = 8'd254;
        else if (k < 14) r[30:23] = 8'($urandom_range(110, 145));
        else r[30:23] = 8'($urandom_range(1, 254));
        return r;
    endfunction

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        int seen = 0;
        rst = 1; in_valid = 1; out_ready = 0; x = 32'h3F800000;
        repeat (3) cyc();
        rst = 0; in_valid = 0;
        checks++;
        if (out_valid !== 0 || got !== '0 || in_ready !== 1) begin
            failures++;
            $display("FAIL reset_state out_valid=%b data=%h in_ready=%b want 0/0/1", out_valid, got, in_ready);
        end
        repeat (10) begin cyc(); seen += int'(out_valid); end
        checks++;
        if (seen != 0) begin failures++; $display("FAIL reset_ignored_input got %0d results want 0", seen); end
    endtask

    task automatic test_vectors();
        logic [31:0] vx[5] = '{32'h3F800000, 32'h43000000, 32'hC0000000, 32'h447A0000, 32'h7FC00000};
        exp_t ve[5] = '{{32'h3F000000, 32'h3F800000, 22'h3FC080, 1'b0},
                        {32'h42800000, 32'h46800000, 22'h000000, 1'b0},
                        {32'hBF800000, 32'h40800000, 22'h3FBF00, 1'b0},
                        {32'h43FA0000, 32'h49742400, 22'h00BFFF, 1'b1},
                        {32'h7FC00000, 32'h7FC00000, 22'h3FC000, 1'b1}};
        int n;
        out_ready = 1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1; x = vx[i];
            checks++;
            if (in_ready !== 1) begin failures++; $display("FAIL vec%0d_in_ready got %b want 1", i, in_ready); end
            cyc();
            in_valid = 0; n = 1;
            while (!out_valid && n < 20) begin cyc(); n++; end
            checks++;
            if (n != 6) begin failures++; $display("FAIL vec%0d_latency got %0d want 6", i, n); end
            checks++;
            if (got !== ve[i]) begin failures++; $display("FAIL vec%0d_data got %h want %h", i, got, ve[i]); end
            cyc();
        end
    endtask

    task automatic test_backpressure();
        int acc = 0, n = 0, bad = 0;
        out_ready = 0;
        repeat (14) begin
            in_valid = 1; x = rand_op();
            if (in_ready) begin acc++; q.push_back(model(x)); end
            cyc();
        end
        in_valid = 0;
        checks++;
        if (acc != 8 || in_ready !== 0) begin
            failures++;
            $display("FAIL bp_fill accepted=%0d in_ready=%b want 8/0", acc, in_ready);
        end
        out_ready = 1;
        repeat (30) begin
            if (out_valid) begin
                n++;
                if (q.size() == 0 || got !== q[0]) bad++;
                if (q.size() != 0) void'(q.pop_front());
            end
            cyc();
        end
        checks++;
        if (n != 8 || bad != 0 || in_ready !== 1) begin
            failures++;
            $display("FAIL bp_drain results=%0d wrong=%0d in_ready=%b want 8/0/1", n, bad, in_ready);
        end
        q.delete();
    endtask

    task automatic test_back_to_back();
        int stall = 0, n = 0, bad = 0;
        out_ready = 1;
        for (int i = 0; i < 60; i++) begin
            in_valid = i < 40; x = rand_op();
            if (in_valid && !in_ready) stall++;
            if (in_valid && in_ready) q.push_back(model(x));
            if (out_valid) begin
                n++;
                if (q.size() == 0 || got !== q[0]) bad++;
                if (q.size() != 0) void'(q.pop_front());
            end
            cyc();
        end
        checks++;
        if (stall != 0 || n != 40 || bad != 0) begin
            failures++;
            $display("FAIL b2b stalls=%0d results=%0d wrong=%0d want 0/40/0", stall, n, bad);
        end
        q.delete();
    endtask

    task automatic test_random();
        int sent = 0, budget = 0, bad = 0, zbad = 0, over = 0;
        bit acc, rd;
        while ((sent < 200 || q.size() != 0) && budget < 5000) begin
            in_valid  = sent < 200 && $urandom_range(0, 9) < 7;
            x         = rand_op();
            out_ready = $urandom_range(0, 9) < 6;
            #1;
            acc = in_valid && in_ready;
            rd  = out_valid && out_ready;
            if (!out_valid && got !== '0) zbad++;
            if (rd) begin
                if (q.size() == 0 || got !== q[0]) begin
                    bad++;
                    if (bad < 5) $display("FAIL rand_result got %h want %h", got, q.size() ? q[0] : '0);
                end
                if (q.size() != 0) void'(q.pop_front());
            end
            if (acc) begin q.push_back(model(x)); sent++; end
            if (q.size() > 8) over++;
            cyc();
            budget++;
        end
        in_valid = 0;
        checks++;
        if (bad != 0) begin failures++; $display("FAIL rand_data wrong=%0d want 0", bad); end
        checks++;
        if (zbad != 0) begin failures++; $display("FAIL rand_idle_zero nonzero=%0d want 0", zbad); end
        checks++;
        if (over != 0) begin failures++; $display("FAIL rand_credit overflows=%0d want 0", over); end
        checks++;
        if (sent != 200 || q.size() != 0) begin
            failures++;
            $display("FAIL rand_timeout sent=%0d pending=%0d want 200/0", sent, q.size());
        end
        q.delete();
    endtask

    task automatic test_reset_midstream();
        int seen = 0, n = 1;
        exp_t e;
        out_ready = 0;
        repeat (4) begin in_valid = 1; x = rand_op(); cyc(); end
        in_valid = 0;
        repeat (8) cyc();
        repeat (3) begin in_valid = 1; x = rand_op(); cyc(); end
        in_valid = 0; rst = 1;
        cyc();
        rst = 0;
        checks++;
        if (out_valid !== 0 || in_ready !== 1 || got !== '0) begin
            failures++;
            $display("FAIL midreset out_valid=%b in_ready=%b data=%h want 0/1/0", out_valid, in_ready, got);
        end
        out_ready = 1;
        repeat (15) begin seen += int'(out_valid); cyc(); end
        checks++;
        if (seen != 0) begin failures++; $display("FAIL midreset_stale results=%0d want 0", seen); end
        in_valid = 1; x = 32'hC0000000; e = model(x);
        cyc();
        in_valid = 0;
        while (!out_valid && n < 20) begin cyc(); n++; end
        checks++;
        if (n != 6 || got !== e) begin
            failures++;
            $display("FAIL midreset_fresh latency=%0d data=%h want 6/%h", n, got, e);
        end
        cyc();
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_vectors();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cordic_prep_pipe.md
# cordic_prep_pipe

Streaming, fully pipelined front-end that turns an IEEE-754 single-precision operand into the three quantities the CORDIC evaluation stage consumes: x/2 (float), x² (float) and an offset/scaled fixed-point angle word. It replaces the one-shot start/done preparation stage. It accepts one operand per cycle under a valid/ready handshake, keeps results in order through a credit-protected output FIFO, and sits directly in front of the CORDIC core.

## Interface
- FLT_W, 32: float width (fixed at 32, binary32 only)
- MUL_LATENCY, 5: latency in cycles of the `fp_mul` instance used for squaring (≥2)
- FRAC_BITS, 14: fractional bits of the internal fixed conversion
- CONV_W, 24: signed width of the internal fixed conversion
- OFFSET, 24'h200000: signed constant subtracted after conversion (128.0 at defaults)
- SHIFT, 7: arithmetic right shift applied after subtraction
- OUT_W, 22: signed width of `x_fixed`
- FIFO_DEPTH, 8: output FIFO entries (power of 2, ≥ MUL_LATENCY+1)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  operand present
- in_ready  out  1  operand accepted when in_valid & in_ready at rising edge
- x  in  FLT_W  operand
- out_valid  out  1  result present at FIFO head
- out_ready  in  1  consumer takes head when out_valid & out_ready
- half  out  FLT_W  x·0.5
- square  out  FLT_W  x·x
- x_fixed  out  OUT_W  signed CORDIC input word
- sat  out  1  x_fixed path saturated for this result

## Operation
- Three parallel paths, all delay-matched to MUL_LATENCY stages, plus a valid shift register of the same length.
- Square: `fp_mul` (dataa=datab=x), clock enable tied high; pipeline never stalls.
- Half (native, no multiplier): exponent e. e∈{0,1} → signed zero (denormals flushed); e=255 → x unchanged; else e−1, sign/mantissa unchanged.
- Fixed: c = trunc-toward-zero(x·2^FRAC_BITS), saturated to CONV_W signed; |x| < 2^−FRAC_BITS → 0; ±inf → saturated max/min; NaN → 0. d = c − OFFSET in CONV_W+1 bits (no overflow). x_fixed = (d >>> SHIFT) saturated to OUT_W signed. sat = 1 if either saturation or NaN occurred.
- Credit: in_flight = valid bits in pipeline, count = FIFO occupancy. in_ready = (in_flight + count) < FIFO_DEPTH; combinational from registered counters only (no dependence on out_ready).
- FIFO: write when pipeline output valid; read on out_valid & out_ready; simultaneous read and write in same cycle legal at any occupancy incl. full; pointers wrap modulo FIFO_DEPTH; order strictly preserved. Credit rule makes overflow impossible; underflow (read when empty) impossible since out_valid = count≠0.
- half/square/x_fixed/sat driven to 0 whenever out_valid=0.

## Timing
- Reset: in_valid ignored; pipeline valids, FIFO pointers and count cleared; cycle after reset: out_valid=0, all data outputs 0, sat=0, in_ready=1. Reset mid-stream discards all in-flight and buffered results.
- Latency: operand accepted at edge of cycle t → out_valid high in cycle t+MUL_LATENCY+1 when FIFO empty (6 at defaults).
- Throughput: one operand/cycle sustained while out_ready=1.
- Backpressure: out_valid and head data held stable until consumed.

## Test plan
- x=0x3F800000 (1.0) → half 0x3F000000, square 0x3F800000, x_fixed 0x3FC080 (−16256), sat 0, out_valid 6 cycles after accept.
- x=0x43000000 (128.0) → half 0x42800000, square 0x46800000, x_fixed 0; x=0xC0000000 (−2.0) → half 0xBF800000, square 0x40800000, x_fixed 0x3FBF00.
- x=1000.0 (0x447A0000) → c saturates 0x7FFFFF, x_fixed 0x00BFFF, sat 1; x=NaN 0x7FC00000 → half 0x7FC00000, x_fixed 0x3FC000, sat 1.
- out_ready=0, in_valid=1 continuously: exactly FIFO_DEPTH accepted, in_ready low thereafter; release out_ready → all 8 results in order, no loss/dup, in_ready reasserts.
- 200 random operands, random in_valid/out_ready: results match reference model in order; count never exceeds FIFO_DEPTH; read+write when full keeps count at 8.
- Assert rst with 3 in flight and 4 buffered → next cycle out_valid 0, in_ready 1; no stale result appears later.
